fp_divider_arbiter: RTL
=======================

Name: fp_divider_arbiter

Overview:
- Shares one pipelined fp_divider (fixed latency, clock-enabled) between NUM_REQ requesters.
- Typical requesters are the autocorrelation normaliser and the downstream Levinson-Durbin LPC solver.
- Arbitrates requests round-robin, drives the divider inputs, and tracks each in-flight operation with a tag pipeline.
- Routes each quotient back to the requester that issued it, and stalls the whole divider pipeline when that requester cannot accept its result.

Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- DIVIDER_DELAY, 14: divider latency in enabled clocks, from registered operands to a valid result.
- WIDTH, 32: IEEE-754 single operand/result width.

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iReqValid  in  NUM_REQ  per-requester request valid.
- iReqNum  in  NUM_REQ*WIDTH  packed numerators; requester k uses bits [k*WIDTH +: WIDTH].
- iReqDen  in  NUM_REQ*WIDTH  packed denominators, same packing.
- oReqReady  out  NUM_REQ  one-hot grant; a request is accepted when iReqValid[k] and oReqReady[k] are both high.
- iRespReady  in  NUM_REQ  requester k can accept a result this cycle.
- oRespValid  out  NUM_REQ  one-hot result valid for requester k.
- oResult  out  WIDTH  quotient; shared bus, qualified by oRespValid.
- oDivNum  out  WIDTH  registered numerator to the divider dataa.
- oDivDen  out  WIDTH  registered denominator to the divider datab.
- oDivEn  out  1  divider clk_en.
- iDivResult  in  WIDTH  divider result.
- oInFlight  out  5  number of accepted operations not yet delivered.
- oIdle  out  1  high when oInFlight==0 and no iReqValid is asserted.

Behaviour:
- Reset values:
  - oReqReady=0, oRespValid=0, oDivNum=0, oDivDen=0x3F800000 (1.0), oDivEn=0, oInFlight=0, oIdle=1.
  - Round-robin pointer=0; all tag stages invalid.
  - Reset mid-operation discards every in-flight operation; no response is produced for it.
- Tag pipeline:
  - DIVIDER_DELAY+1 stages, each holding {valid, requester id}.
  - Stage 0 is loaded in the same edge that loads oDivNum/oDivDen.
  - Tags advance only when oDivEn=1.
- Stall:
  - stall = tail.valid && !iRespReady[tail.id].
  - oDivEn = !stall (combinational).
  - During stall, oDivEn=0 and tags, oDivNum, oDivDen hold.
  - oRespValid stays asserted with a stable oResult, and no grant is issued.
- Delivery:
  - oRespValid[k] = tail.valid && tail.id==k.
  - oResult = iDivResult.
  - The result is delivered in the cycle where oRespValid[k] && iRespReady[k].
- Grant:
  - When not stalled, search iReqValid starting at pointer, wrapping modulo NUM_REQ.
  - The first requester found is granted: oReqReady one-hot, combinational from iReqValid and the registered pointer.
  - On acceptance:
    - oDivNum <= its numerator, oDivDen <= its denominator;
    - stage0 <= {1, k};
    - pointer <= (k+1) mod NUM_REQ.
  - No request accepted: stage0 <= invalid; oDivNum/oDivDen hold; pointer holds.
  - At most one acceptance per cycle.
- Latency:
  - A result reaches oRespValid exactly DIVIDER_DELAY+1 non-stalled cycles after its acceptance cycle.
  - Results to the same requester return in acceptance order.
  - Throughput is 1 op/cycle when no stalls occur.
- Fairness: a requester holding iReqValid high is granted within NUM_REQ non-stalled cycles.
- Request rules: a requester must hold iReqValid and its operands stable until accepted; dropping valid before acceptance is legal and cancels the request.
- Simultaneous events:
  - Acceptance and delivery in the same cycle leave oInFlight unchanged.
  - Otherwise oInFlight increments on acceptance and decrements on delivery; it saturates at DIVIDER_DELAY+1, which the pipeline depth cannot exceed.
- Arithmetic: no operand inspection. Divide-by-zero and NaN results pass through from the divider unchanged.

Test Plan:
- Single request:
  - Stimulus: requester 0 sends 0x40C00000/0x40400000 (6.0/3.0), all iRespReady=1.
  - Required: oReqReady[0] the same cycle; oRespValid[0]=1 with oResult=0x40000000 exactly 15 cycles later; oInFlight returns 0.
- Contention:
  - Stimulus: both requesters hold valid for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1; results return in the same order, each tagged to the correct requester.
- Back-pressure:
  - Stimulus: requester 1 has iRespReady=0 when its result reaches the tail, held for 5 cycles.
  - Required: oDivEn=0 for those 5 cycles; oResult stable; no grants; remaining results arrive 5 cycles late and are intact.
- Back-to-back throughput:
  - Stimulus: 20 consecutive requests from requester 0.
  - Required: 20 accepted in 20 cycles; 20 correct quotients on consecutive cycles 15..34 after the first acceptance.
- Reset mid-flight:
  - Stimulus: 3 operations in flight, then iReset pulsed for 1 cycle.
  - Required: all outputs return to their reset values; oRespValid never asserts for the discarded operations; oIdle=1.
- Cancelled request:
  - Stimulus: requester 1 raises valid during a stall, then drops it before the stall ends.
  - Required: no acceptance from requester 1; oInFlight is unaffected.

Source files
------------

// File: rtl/fp_divider_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined fp divider between NUM_REQ requesters.
// A tag pipeline tracks the owner of each in-flight quotient; a blocked owner stalls the divider.
module fp_divider_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned DIVIDER_DELAY = 14,
  parameter int unsigned WIDTH         = 32
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic [NUM_REQ-1:0]         iReqValid,
  input  logic [NUM_REQ*WIDTH-1:0]   iReqNum,
  input  logic [NUM_REQ*WIDTH-1:0]   iReqDen,
  output logic [NUM_REQ-1:0]         oReqReady,
  input  logic [NUM_REQ-1:0]         iRespReady,
  output logic [NUM_REQ-1:0]         oRespValid,
  output logic [WIDTH-1:0]           oResult,
  output logic [WIDTH-1:0]           oDivNum,
  output logic [WIDTH-1:0]           oDivDen,
  output logic                       oDivEn,
  input  logic [WIDTH-1:0]           iDivResult,
  output logic [4:0]                 oInFlight,
  output logic                       oIdle
);

  localparam int unsigned IdW         = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned Stages      = DIVIDER_DELAY + 1;
  localparam logic [4:0]  MaxInFlight = 5'(Stages);
  localparam logic [WIDTH-1:0] OneF   = WIDTH'(32'h3F80_0000);

  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [4:0]        inflight_q, inflight_d;
  logic [Stages-1:0] tag_valid_q;
  logic [IdW-1:0]    tag_id_q [Stages];

  logic              tail_valid;
  logic [IdW-1:0]    tail_id;
  logic              stall;
  logic              accept;
  logic              deliver;
  logic [IdW-1:0]    grant_id;
  logic [IdW-1:0]    idx;
  logic [WIDTH-1:0]  sel_num, sel_den;

  assign tail_valid = tag_valid_q[Stages-1];
  assign tail_id    = tag_id_q[Stages-1];

  // Reset masks the tail so a discarded operation never presents a response.
  always_comb begin
    oRespValid = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      oRespValid[k] = !iReset && tail_valid && (tail_id == IdW'(k));
    end
  end

  assign stall   = |(oRespValid & ~iRespReady);
  assign deliver = |(oRespValid & iRespReady);
  assign oDivEn  = !iReset && !stall;
  assign oResult = iDivResult;

  // Round-robin search starting at the registered pointer.
  always_comb begin
    oReqReady = '0;
    accept    = 1'b0;
    grant_id  = '0;
    idx       = '0;
    sel_num   = '0;
    sel_den   = '0;
    if (!iReset && !stall) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = IdW'((32'(ptr_q) + i) % NUM_REQ);
        if (!accept && iReqValid[idx]) begin
          accept         = 1'b1;
          grant_id       = idx;
          oReqReady[idx] = 1'b1;
          sel_num        = iReqNum[idx*WIDTH +: WIDTH];
          sel_den        = iReqDen[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !deliver && inflight_q < MaxInFlight) begin
      inflight_d = inflight_q + 5'd1;
    end else if (deliver && !accept && inflight_q != '0) begin
      inflight_d = inflight_q - 5'd1;
    end
  end

  assign oInFlight = inflight_q;
  assign oIdle     = (inflight_q == '0) && !(|iReqValid);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      ptr_q       <= '0;
      inflight_q  <= '0;
      tag_valid_q <= '0;
      oDivNum     <= '0;
      oDivDen     <= OneF;
      for (int unsigned s = 0; s < Stages; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      if (accept) begin
        oDivNum <= sel_num;
        oDivDen <= sel_den;
      end
      // Tags move in lockstep with the divider's clock enable.
      if (!stall) begin
        tag_valid_q <= {tag_valid_q[Stages-2:0], accept};
        tag_id_q[0] <= grant_id;
        for (int unsigned s = 1; s < Stages; s++) begin
          tag_id_q[s] <= tag_id_q[s-1];
        end
      end
    end
  end

endmodule
